tree_adder_arbiter: RTL and testbench
=====================================

# tree_adder_arbiter

Round-robin scheduler that shares one pipelined balanced tree adder among R requesters. Each requester presents a full leaf vector of 2^N operands. The block grants at most one requester per cycle and registers the granted vector onto the tree input. It carries the requester id alongside the tree's fixed pipeline latency and returns each sum tagged with its owner. It sits between the requesting engines and the tree adder instance; the tree itself is external.

## Interface
- N, 4, log2 of tree leaf count (2^N operands per request)
- DW, 8, operand width
- R, 4, number of requesters (2..16)
- LAT, 4, tree latency in cycles from tree_inp change to matching tree_outp
- SW, DW+N, tree sum width
- IDW, clog2(R), width of requester id
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  R  request pending, one bit per requester
- req_data  in  R*(2^N)*DW  leaf vectors; requester i occupies slice i
- req_ready  out  R  one-hot grant, combinational; all zero when none
- hold  in  1  suppresses new grants while high
- tree_inp  out  (2^N)*DW  registered leaf vector to the tree
- tree_outp  in  SW  sum from the tree
- rsp_valid  out  1  result valid, one-cycle pulse per accepted request
- rsp_id  out  IDW  requester that owns rsp_sum
- rsp_sum  out  SW  equals tree_outp, qualified by rsp_valid
- idle  out  1  high when no request is in flight

## Operation
- **Grant.** Search starts at pointer ptr, ascending with wrap modulo R. The first i with req_valid[i]=1 is granted (req_ready[i]=1). No grant when hold=1 or rst=1.
- **Accept and pointer update.** Accept means req_valid[i] and req_ready[i] in the same cycle. On accept:
  - ptr <= (i+1) mod R
  - tree_inp <= req_data slice i
- **No accept.** ptr and tree_inp hold.
- **Requester contract.** A requester keeps req_valid and its data stable until accepted. It may drop req_valid before accept; the block does not check this.
- **Tag pipe.** LAT+1 stages of {valid, id}, shifted every cycle. Stage 0 loads {accept, granted id}. The last stage drives rsp_valid/rsp_id.
- **Response data.** rsp_sum is tree_outp directly, with no extra register.
- **Inflight counter.** Range 0..LAT+1.
  - +1 on accept, −1 on rsp_valid.
  - Both in the same cycle: unchanged.
  - idle = (inflight==0).
- **Back-to-back.** One accept per cycle is sustained indefinitely. There is no output backpressure; consumers must take rsp the cycle it is valid.
- **Reset values.** rst=1 at a clock edge sets:
  - ptr=0, tree_inp=0, all tag stages invalid, inflight=0
  - rsp_valid=0, rsp_id=0, idle=1
- **Reset mid-operation.** Requests in flight are dropped; no rsp_valid pulse is produced for them. Tree outputs that arrive afterward are ignored, because their tags were cleared.
- **Hold.** Affects grants only. Requests already in flight still complete and emit rsp.

## Timing
- Accept in cycle t: tree_inp carries the vector from cycle t+1; rsp_valid=1 in cycle t+LAT+1 with the matching id and sum.
- req_ready depends combinationally on req_valid, hold, ptr and rst. No combinational path from tree_outp to any control output.
- Fairness: with all R requesters continuously valid and hold=0, grants rotate 0,1,…,R−1,0,… and each requester waits at most R−1 cycles.
- The first grant after reset, or after any idle cycle, occurs in the same cycle req_valid is seen.
- Sum width: SW bits cover the full 2^N·(2^DW−1) range without overflow; the block never truncates it.

## Test plan
- **Reset state.** Hold rst for 3 cycles with all req_valid=1.
  - Required: req_ready=0, rsp_valid=0, idle=1, tree_inp=0.
  - After release: first grant goes to requester 0.
- **Single request.** Defaults; requester 2 requests with all 16 operands = 8'd5 at cycle t.
  - Required: req_ready=4'b0100 at t.
  - rsp_valid at t+5 with rsp_id=2 and rsp_sum=80 (behavioural tree model).
  - idle=0 from t+1 through t+5; idle=1 at t+6.
- **Full contention.** All 4 requesters valid for 8 cycles.
  - Required grant order: 0,1,2,3,0,1,2,3.
  - rsp_id order identical, delayed by 5 cycles; inflight peaks at 5.
- **Wrap and skip.** Only requesters 3 and 1 valid, ptr=2.
  - Required: 3 granted, then 1, then 3.
  - Requesters 0 and 2 are never granted.
- **Hold.** Assert hold for 4 cycles while 2 requests are in flight and requester 0 is valid.
  - Required: no grants during hold; both in-flight responses still emerge on schedule.
  - Requester 0 is granted the cycle hold drops.
- **Reset mid-flight.** Pulse rst 2 cycles after 3 back-to-back accepts.
  - Required: no rsp_valid for those 3 requests; idle=1 the cycle after the rst edge; ptr=0.
  - Maximum operand values (16×255) in a later request return rsp_sum=4080 with no overflow.

Source files
------------

// File: rtl/tree_adder_arbiter.sv
// rtl/tree_adder_arbiter.sv - round-robin front end sharing one pipelined tree adder among R requesters
module tree_adder_arbiter #(
  parameter int N   = 4,
  parameter int DW  = 8,
  parameter int R   = 4,
  parameter int LAT = 4,
  parameter int SW  = DW + N,
  parameter int IDW = $clog2(R)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [R-1:0]                req_valid,
  input  logic [R*(2**N)*DW-1:0]      req_data,
  output logic [R-1:0]                req_ready,
  input  logic                        hold,
  output logic [(2**N)*DW-1:0]        tree_inp,
  input  logic [SW-1:0]               tree_outp,
  output logic                        rsp_valid,
  output logic [IDW-1:0]              rsp_id,
  output logic [SW-1:0]               rsp_sum,
  output logic                        idle
);

  localparam int VW  = (2**N) * DW;
  localparam int IFW = $clog2(LAT + 2);
  localparam logic [IDW:0]   R_EXT  = (IDW+1)'(R);
  localparam logic [IDW-1:0] R_LAST = IDW'(R - 1);

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] gnt_id;
  logic [IDW:0]   pos;
  logic           accept;
  logic [VW-1:0]  req_vec [R];
  logic [LAT:0]   tag_v;
  logic [IDW-1:0] tag_id [LAT+1];
  logic [IFW-1:0] inflight;

  for (genvar g = 0; g < R; g++) begin : g_slice
    assign req_vec[g] = req_data[g*VW +: VW];
  end

  // Scan R slots starting at ptr; the first pending requester wins.
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    accept    = 1'b0;
    pos       = '0;
    if (!rst && !hold) begin
      for (int k = 0; k < R; k++) begin
        pos = {1'b0, ptr} + (IDW+1)'(k);
        if (pos >= R_EXT) pos = pos - R_EXT;
        if (!accept && req_valid[pos[IDW-1:0]]) begin
          accept = 1'b1;
          gnt_id = pos[IDW-1:0];
        end
      end
      if (accept) req_ready[gnt_id] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= '0;
      tree_inp <= '0;
      tag_v    <= '0;
      inflight <= '0;
      for (int s = 0; s <= LAT; s++) tag_id[s] <= '0;
    end else begin
      if (accept) begin
        ptr      <= (gnt_id == R_LAST) ? '0 : gnt_id + IDW'(1);
        tree_inp <= req_vec[gnt_id];
      end
      // The tag rides alongside the tree so the owner lines up with its sum.
      tag_v     <= {tag_v[LAT-1:0], accept};
      tag_id[0] <= gnt_id;
      for (int s = 1; s <= LAT; s++) tag_id[s] <= tag_id[s-1];
      case ({accept, rsp_valid})
        2'b10:   inflight <= inflight + IFW'(1);
        2'b01:   inflight <= inflight - IFW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  assign rsp_valid = tag_v[LAT];
  assign rsp_id    = tag_id[LAT];
  assign rsp_sum   = tree_outp;
  assign idle      = (inflight == '0);

endmodule

// File: tb/tb_tree_adder_arbiter.sv
// tb/tb_tree_adder_arbiter.sv - directed and random checks of tree_adder_arbiter against a queue model
module tb_tree_adder_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int R   = 4;
  localparam int LAT = 4;
  localparam int SW  = DW + N;
  localparam int IW  = 2;
  localparam int VW  = (2**N) * DW;
  localparam int AW  = R * VW;
  localparam int CW  = 256;

  logic           clk;
  logic           rst;
  logic [R-1:0]   req_valid;
  logic [AW-1:0]  req_data;
  logic [R-1:0]   req_ready;
  logic           hold;
  logic [VW-1:0]  tree_inp;
  logic [SW-1:0]  tree_outp;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic [SW-1:0]  rsp_sum;
  logic           idle;

  tree_adder_arbiter #(.N(N), .DW(DW), .R(R), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .hold(hold), .tree_inp(tree_inp), .tree_outp(tree_outp),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .idle(idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [SW-1:0] sum_vec(input logic [VW-1:0] x);
    logic [SW-1:0] s;
    logic [VW-1:0] t;
    s = '0;
    t = x;
    for (int i = 0; i < 2**N; i++) begin
      s = s + SW'(t[DW-1:0]);
      t = t >> DW;
    end
    return s;
  endfunction

  // External tree: sum of tree_inp appears LAT cycles after tree_inp changes.
  logic [SW-1:0] tpipe [LAT];
  always @(posedge clk) begin
    tpipe[0] <= sum_vec(tree_inp);
    for (int k = 1; k < LAT; k++) tpipe[k] <= tpipe[k-1];
  end
  assign tree_outp = tpipe[LAT-1];

  typedef struct {
    int            due;
    int            id;
    logic [SW-1:0] sum;
  } rsp_t;

  rsp_t          q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc   = 0;
  int            mptr  = 0;
  int            gnt   = -1;
  bit            known = 1'b0;
  logic [VW-1:0] m_tree = '0;
  logic [R-1:0]  v;
  logic [VW-1:0] d [R];
  logic          h;
  logic          r;

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    logic [AW-1:0] bus;
    logic [R-1:0]  er;
    bit            due;
    int            g;
    int            idx;
    @(negedge clk);
    rst  = r;
    hold = h;
    req_valid = v;
    bus = '0;
    for (int i = R - 1; i >= 0; i--) bus = (bus << VW) | AW'(d[IW'(i)]);
    req_data = bus;
    #1;
    g = -1;
    if (!r && !h)
      for (int k = 0; k < R; k++) begin
        idx = (mptr + k) % R;
        if (g < 0 && v[IW'(idx)]) g = idx;
      end
    er = '0;
    if (g >= 0) er[IW'(g)] = 1'b1;
    chk("req_ready", CW'(req_ready), CW'(er));
    due = known && q.size() > 0 && q[0].due == cyc;
    if (known) begin
      chk("rsp_valid", CW'(rsp_valid), CW'(due));
      if (due) begin
        chk("rsp_id", CW'(rsp_id), CW'(q[0].id));
        chk("rsp_sum", CW'(rsp_sum), CW'(q[0].sum));
      end
      chk("idle", CW'(idle), CW'(q.size() == 0));
      chk("tree_inp", CW'(tree_inp), CW'(m_tree));
    end
    if (due) void'(q.pop_front());
    if (r) begin
      q.delete();
      mptr   = 0;
      m_tree = '0;
      known  = 1'b1;
    end else if (g >= 0) begin
      q.push_back('{cyc + LAT + 1, g, sum_vec(d[IW'(g)])});
      mptr   = (g + 1) % R;
      m_tree = d[IW'(g)];
    end
    gnt = g;
    cyc++;
  endtask

  task automatic drain(input int n);
    v = '0;
    h = 1'b0;
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; req_valid = '0; req_data = '0;
    r = 1'b1; h = 1'b0; v = '1;
    for (int i = 0; i < R; i++) d[IW'(i)] = rand_vec();

    // Reset with every requester asking
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_ready", CW'(req_ready), CW'(0));
    end
    chk("rst_idle", CW'(idle), CW'(1));
    chk("rst_rsp_valid", CW'(rsp_valid), CW'(0));
    chk("rst_tree_inp", CW'(tree_inp), CW'(0));
    r = 1'b0;
    step();
    chk("first_grant", CW'(req_ready), CW'(4'b0001));
    drain(LAT + 3);

    // Single request from requester 2
    d[IW'(2)] = {16{8'd5}};
    v = 4'b0100;
    step();
    chk("single_ready", CW'(req_ready), CW'(4'b0100));
    v = '0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("single_busy", CW'(idle), CW'(0));
    end
    chk("single_rsp_valid", CW'(rsp_valid), CW'(1));
    chk("single_rsp_id", CW'(rsp_id), CW'(2));
    chk("single_rsp_sum", CW'(rsp_sum), CW'(80));
    step();
    chk("single_idle", CW'(idle), CW'(1));

    // Full contention after a fresh reset
    r = 1'b1; step(); r = 1'b0;
    v = '1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("contend_grant", CW'(req_ready), CW'(4'(1) << (k % 4)));
      if (gnt >= 0) d[IW'(gnt)] = rand_vec();
    end
    drain(LAT + 3);

    // Wrap and skip with ptr steered to 2
    v = 4'b0010;
    step();
    v = 4'b1010;
    step();
    chk("wrap_3a", CW'(req_ready), CW'(4'b1000));
    d[IW'(3)] = rand_vec();
    step();
    chk("wrap_1", CW'(req_ready), CW'(4'b0010));
    d[IW'(1)] = rand_vec();
    step();
    chk("wrap_3b", CW'(req_ready), CW'(4'b1000));
    drain(LAT + 3);

    // Hold while two requests are in flight
    v = 4'b0010; step();
    v = 4'b0100; step();
    v = 4'b0001; h = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_no_grant", CW'(req_ready), CW'(0));
    end
    h = 1'b0;
    step();
    chk("hold_release", CW'(req_ready), CW'(4'b0001));
    drain(LAT + 3);

    // Reset two cycles after three back-to-back accepts
    v = '1;
    for (int k = 0; k < 3; k++) begin
      step();
      if (gnt >= 0) d[IW'(gnt)] = rand_vec();
    end
    v = '0;
    step();
    r = 1'b1; step(); r = 1'b0;
    step();
    chk("midrst_idle", CW'(idle), CW'(1));
    for (int k = 0; k < 5; k++) begin
      step();
      chk("midrst_no_rsp", CW'(rsp_valid), CW'(0));
    end
    d[IW'(0)] = '1;
    v = '1;
    step();
    chk("midrst_ptr0", CW'(req_ready), CW'(4'b0001));
    v = '0;
    repeat (5) step();
    chk("max_rsp_valid", CW'(rsp_valid), CW'(1));
    chk("max_rsp_sum", CW'(rsp_sum), CW'(4080));
    drain(LAT + 3);

    // Random traffic, holds and occasional resets
    for (int c = 0; c < 600; c++) begin
      r = ($urandom_range(0, 79) == 0);
      h = ($urandom_range(0, 6) == 0);
      for (int i = 0; i < R; i++)
        if (!v[IW'(i)] && $urandom_range(0, 1) == 1) begin
          v[IW'(i)] = 1'b1;
          d[IW'(i)] = rand_vec();
        end
      step();
      if (gnt >= 0) v[IW'(gnt)] = 1'b0;
    end
    r = 1'b0;
    drain(LAT + 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
